instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage for the multicycle MIPS CPU, sitting directly upstream of the control FSM. Holds the program counter and instruction register, fetches from instruction memory over a req/ack handshake, and presents decoded fields (opcode, funct, rs, rt, rd, imm, target) to the FSM and datapath. Computes the next PC from FSM-supplied jump/branch controls and the ALU zero flag.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_ack (used only with IF_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- fetch_start  input  1  FSM request to fetch instruction at current PC (FSM instrReg)
- pc_wr  input  1  commit next-PC selection this cycle
- pc_sel  input  2  0 = PC+4, 1 = branch, 2 = jump (j/jal), 3 = register (jr)
- beq, bne  input  1 each  branch type from FSM
- zero  input  1  ALU zero flag
- jr_addr  input  32  rs register value for jr
- mem_req  output  1  instruction memory request
- mem_addr  output  32  fetch address (= PC)
- mem_ack  input  1  memory data valid this cycle
- mem_rdata  input  32  instruction word
- ir_valid  output  1  IR holds a freshly fetched instruction
- opcode  output  6  IR[31:26]
- funct  output  6  IR[5:0]
- rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11]
- imm  output  16  IR[15:0]
- target  output  26  IR[25:0]
- pc  output  32  address of instruction in IR
- pc_plus4  output  32  pc + 4 (jal link value)
- fetch_err  output  1  fetch timeout (constant 0 without IF_TIMEOUT_EN)

## Operation
- States: IDLE, FETCH, VALID, ERR (ERR exists only with IF_TIMEOUT_EN).
- IDLE/VALID + fetch_start -> FETCH. FETCH + mem_ack -> VALID, IR <= mem_rdata. FETCH without ack -> stay.
- mem_req = 1 exactly in FETCH; mem_addr = pc register at all times.
- Next PC on pc_wr (accepted in IDLE and VALID only; ignored in FETCH and ERR):
  - 0: pc+4
  - 1: taken = (beq & zero) | (bne & ~zero); taken -> pc+4 + (sext(imm) << 2), else pc+4
  - 2: {pc_plus4[31:28], target, 2'b00}
  - 3: jr_addr
- All PC arithmetic 32-bit, wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- pc_wr and fetch_start in same cycle: PC updates and FETCH entered on same edge; the fetch uses the new PC.
- ir_valid = 1 in VALID, cleared on the edge leaving VALID (fetch_start) and by pc_wr (IR now stale vs PC).
- Decoded field outputs are pure slices of IR; IR only changes on mem_ack in FETCH.
- mem_ack outside FETCH ignored.

## Timing
- Reset (reset_n = 0 at edge): pc = RESET_PC, IR = 0, state IDLE, mem_req = 0, ir_valid = 0, fetch_err = 0; all decoded fields 0, pc_plus4 = RESET_PC+4. Reset mid-fetch aborts; subsequent ack ignored.
- fetch_start at edge N -> mem_req high from N+1; ack at edge M (M >= N+1) -> ir_valid and new IR visible after M; minimum fetch latency 2 cycles.
- pc_wr at edge N -> new pc visible after N.

## Configuration
- IF_TIMEOUT_EN defined: a counter runs in FETCH; if TIMEOUT_CYCLES edges pass with no mem_ack, go to ERR, drop mem_req, assert fetch_err (sticky until reset). Ack on the exact timeout edge wins (VALID).
- Undefined: no counter, no ERR state, FETCH waits indefinitely, fetch_err tied 0.

## Structure
- Shared package cpu_pkg: opcode/funct constants (LW 0x23, SW 0x2b, J 0x2, JAL 0x3, BEQ 0x4, BNE 0x5, XORI 0xe, ADDI 0x8, R-type 0x0, JR 0x08, ADD 0x20, SUB 0x22, SLT 0x2a), pc_sel encodings, fetch state encoding.
- One sub-module: next_pc_calc (combinational next-PC mux and branch/jump address arithmetic).

## Test plan
- Reset, fetch_start, ack after 3 cycles with 0x0109_402A -> opcode 0x00, funct 0x2a, rs 8, rt 9, rd 8, pc 0, ir_valid 1.
- pc = 0x100, pc_wr with pc_sel 1, beq=1, zero=1, imm 0xFFFE -> pc 0xFC; same with zero=0 -> 0x104; bne=1, zero=0 -> 0xFC.
- pc = 0x9000_0010, pc_sel 2, target 0x0000040 -> pc 0x9000_0100; pc_sel 3, jr_addr 0x1234 -> pc 0x1234.
- pc_wr and fetch_start same cycle -> mem_addr equals new PC on first mem_req cycle; pc_wr during FETCH -> pc unchanged.
- reset_n low during FETCH, ack arrives next cycle -> state IDLE, IR 0, ir_valid 0.
- IF_TIMEOUT_EN, TIMEOUT_CYCLES 4, never ack -> fetch_err 1 after 4 FETCH cycles, mem_req 0; ack on 4th edge -> ir_valid 1, fetch_err 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: opcode/funct constants,
// next-PC select encodings and the instruction-fetch state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_JR     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

  // Sign-extended word offset of a branch immediate, in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, j/jal
// region jump and jr register target. All arithmetic wraps modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic taken;

  assign pc_plus4 = pc + 32'd4;
  assign taken    = (beq & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_sel)
      PC_SEL_SEQ:    next_pc = pc_plus4;
      PC_SEL_BRANCH: next_pc = taken ? (pc_plus4 + branch_offset(imm)) : pc_plus4;
      PC_SEL_JUMP:   next_pc = {pc_plus4[31:28], target, 2'b00};
      PC_SEL_JR:     next_pc = jr_addr;
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, IR, memory req/ack fetch FSM and decoded fields.
// Optional fetch timeout with ERR state is enabled by defining IF_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         fetch_start,
  input  logic         pc_wr,
  input  logic [1:0]   pc_sel,
  input  logic         beq,
  input  logic         bne,
  input  logic         zero,
  input  logic [31:0]  jr_addr,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         ir_valid,
  output logic [5:0]   opcode,
  output logic [5:0]   funct,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [15:0]  imm,
  output logic [25:0]  target,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         fetch_err,
  output fetch_state_t fsm_state
);

  // Memory handshake: mem_req stays high for every cycle spent in FETCH and
  // mem_addr is always the PC. A rising edge with mem_req & mem_ack transfers
  // mem_rdata into IR; mem_ack while mem_req is low is ignored.

  fetch_state_t state, state_next;
  logic [31:0]  ir;
  logic [31:0]  next_pc;
  logic         accept;
  logic         ack_hit;
  logic         timeout_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_VALID: if (fetch_start) state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)          state_next = ST_VALID;
        else if (timeout_hit) state_next = ST_ERR;
      end
`ifdef IF_TIMEOUT_EN
      ST_ERR:  state_next = ST_ERR;
`else
      ST_ERR:  state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req   = 1'b0;
    fetch_err = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE:  accept = 1'b1;
      ST_FETCH: mem_req = 1'b1;
      ST_VALID: accept = 1'b1;
`ifdef IF_TIMEOUT_EN
      ST_ERR:   fetch_err = 1'b1;
`else
      ST_ERR:   fetch_err = 1'b0;
`endif
      default:  accept = 1'b0;
    endcase
  end

  assign ack_hit   = mem_req & mem_ack;
  assign fsm_state = state;

`ifdef IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Counts FETCH edges without an ack; an ack on the final edge still wins.
  always_ff @(posedge clk) begin
    if (!reset_n || state != ST_FETCH) wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_FETCH) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  next_pc_calc u_next_pc (
    .pc       (pc),
    .pc_sel   (pc_sel),
    .beq      (beq),
    .bne      (bne),
    .zero     (zero),
    .imm      (ir[15:0]),
    .target   (ir[25:0]),
    .jr_addr  (jr_addr),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (accept && pc_wr) pc <= next_pc;
      if (ack_hit)         ir <= mem_rdata;
      // A PC change makes the held IR stale relative to pc.
      if (ack_hit)                                ir_valid <= 1'b1;
      else if (accept && (pc_wr || fetch_start))  ir_valid <= 1'b0;
    end
  end

  assign mem_addr = pc;
  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm      = ir[15:0];
  assign funct    = ir[5:0];
  assign target   = ir[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written multi-cycle
// sequences and randomized cycles checked against a behavioural model.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          T        = 4;

  typedef struct {
    logic        rst_n;
    logic        fs;
    logic        pw;
    logic [1:0]  sel;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [31:0] jr;
    logic        ack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
    logic        req;
  } vec_t;

  logic         clk, reset_n, fetch_start, pc_wr, beq, bne, zero;
  logic [1:0]   pc_sel;
  logic [31:0]  jr_addr, mem_addr, mem_rdata, pc, pc_plus4;
  logic         mem_req, mem_ack, ir_valid, fetch_err;
  logic [5:0]   opcode, funct;
  logic [4:0]   rs, rt, rd;
  logic [15:0]  imm;
  logic [25:0]  target;
  fetch_state_t fsm_state;

  instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .pc_wr(pc_wr),
    .pc_sel(pc_sel), .beq(beq), .bne(bne), .zero(zero), .jr_addr(jr_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir_valid(ir_valid), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset_n = 1'b0; fetch_start = 1'b0; pc_wr = 1'b0; pc_sel = 2'd0;
    beq = 1'b0; bne = 1'b0; zero = 1'b0; jr_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Behavioural model: PC, IR, whether IR is fresh, whether a fetch is
  // outstanding, how long it has waited, and whether it timed out.
  logic [31:0] m_pc, m_ir;
  bit          m_valid, m_busy, m_err;
  int          m_wait;

  function automatic logic [31:0] model_next(input stim_t s);
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    off = int'($signed(m_ir[15:0])) * 4;
    case (s.sel)
      2'd0: return seq;
      2'd1: return ((s.beq && s.zero) || (s.bne && !s.zero)) ? seq + 32'(off) : seq;
      2'd2: return {seq[31:28], m_ir[25:0], 2'b00};
      default: return s.jr;
    endcase
  endfunction

  task automatic model_update(input stim_t s);
    if (!s.rst_n) begin
      m_pc = RESET_PC; m_ir = '0; m_valid = 0; m_busy = 0; m_err = 0; m_wait = 0;
    end else if (m_busy) begin
      if (s.ack) begin
        m_ir = s.rdata; m_valid = 1; m_busy = 0;
        exp_q.push_back(s.rdata);
      end else begin
        m_wait++;
`ifdef IF_TIMEOUT_EN
        if (m_wait >= T) begin m_busy = 0; m_err = 1; end
`endif
      end
    end else if (!m_err) begin
      if (s.pw) begin m_pc = model_next(s); m_valid = 0; end
      if (s.fs) begin m_busy = 1; m_valid = 0; m_wait = 0; end
    end
  endtask

  function automatic stim_t st(input logic fs, input logic pw, input logic [1:0] sel,
                               input logic b_eq, input logic b_ne, input logic z,
                               input logic [31:0] jr, input logic ack,
                               input logic [31:0] rdata);
    stim_t s;
    s.rst_n = 1'b1; s.fs = fs; s.pw = pw; s.sel = sel; s.beq = b_eq; s.bne = b_ne;
    s.zero = z; s.jr = jr; s.ack = ack; s.rdata = rdata;
    return s;
  endfunction

  // Driver: apply one cycle of stimulus, sample #1 after the edge.
  task automatic step(input stim_t s);
    reset_n = s.rst_n; fetch_start = s.fs; pc_wr = s.pw; pc_sel = s.sel;
    beq = s.beq; bne = s.bne; zero = s.zero; jr_addr = s.jr;
    mem_ack = s.ack; mem_rdata = s.rdata;
    @(posedge clk);
    #1;
    model_update(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_ir, input logic e_valid,
                               input logic e_req, input logic e_err);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    check({tag, " mem_addr"}, mem_addr, e_pc);
    check({tag, " mem_req"}, 32'(mem_req), 32'(e_req));
    check({tag, " ir_valid"}, 32'(ir_valid), 32'(e_valid));
    check({tag, " fetch_err"}, 32'(fetch_err), 32'(e_err));
    check({tag, " opcode"}, 32'(opcode), 32'(e_ir[31:26]));
    check({tag, " rs"}, 32'(rs), 32'(e_ir[25:21]));
    check({tag, " rt"}, 32'(rt), 32'(e_ir[20:16]));
    check({tag, " rd"}, 32'(rd), 32'(e_ir[15:11]));
    check({tag, " funct"}, 32'(funct), 32'(e_ir[5:0]));
    check({tag, " imm"}, 32'(imm), 32'(e_ir[15:0]));
    check({tag, " target"}, 32'(target), 32'(e_ir[25:0]));
  endtask

  vec_t tbl[$];

  task automatic add(input stim_t s, input logic [31:0] e_pc, input logic [31:0] e_ir,
                     input logic e_valid, input logic e_req);
    vec_t v;
    v.s = s; v.pc = e_pc; v.ir = e_ir; v.valid = e_valid; v.req = e_req;
    tbl.push_back(v);
  endtask

  initial begin
    stim_t s;
    logic [31:0] w;

    // Reset state
    s = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.rst_n = 1'b0;
    step(s);
    step(s);
    check_outputs("reset", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset state", 32'(fsm_state), 32'(ST_IDLE));

    // Directed vectors: fetch, branches, jumps, same-cycle and wrap cases
    add(st(1, 0, 0, 0, 0, 0, 0, 0, 0),                  32'h0, 32'h0, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0),                  32'h0, 32'h0, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 0, 0),                  32'h0, 32'h0, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h0109_402A),      32'h0, 32'h0109_402A, 1, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'h100, 0, 0),            32'h100, 32'h0109_402A, 0, 0);
    add(st(1, 0, 0, 0, 0, 0, 0, 0, 0),                  32'h100, 32'h0109_402A, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000_FFFE),      32'h100, 32'h1000_FFFE, 1, 0);
    add(st(0, 1, 1, 1, 0, 1, 0, 0, 0),                  32'hFC,  32'h1000_FFFE, 0, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'h100, 0, 0),            32'h100, 32'h1000_FFFE, 0, 0);
    add(st(0, 1, 1, 1, 0, 0, 0, 0, 0),                  32'h104, 32'h1000_FFFE, 0, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'h100, 0, 0),            32'h100, 32'h1000_FFFE, 0, 0);
    add(st(0, 1, 1, 0, 1, 0, 0, 0, 0),                  32'hFC,  32'h1000_FFFE, 0, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'h9000_0010, 0, 0),      32'h9000_0010, 32'h1000_FFFE, 0, 0);
    add(st(1, 0, 0, 0, 0, 0, 0, 0, 0),                  32'h9000_0010, 32'h1000_FFFE, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h0800_0040),      32'h9000_0010, 32'h0800_0040, 1, 0);
    add(st(0, 1, 2, 0, 0, 0, 0, 0, 0),                  32'h9000_0100, 32'h0800_0040, 0, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'h1234, 0, 0),           32'h1234, 32'h0800_0040, 0, 0);
    add(st(1, 1, 3, 0, 0, 0, 32'h2000, 0, 0),           32'h2000, 32'h0800_0040, 0, 1);
    add(st(0, 1, 3, 0, 0, 0, 32'h5555, 0, 0),           32'h2000, 32'h0800_0040, 0, 1);
    add(st(0, 0, 0, 0, 0, 0, 0, 1, 32'hAABB_CCDD),      32'h2000, 32'hAABB_CCDD, 1, 0);
    add(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222),      32'h2000, 32'hAABB_CCDD, 1, 0);
    add(st(0, 1, 3, 0, 0, 0, 32'hFFFF_FFFC, 0, 0),      32'hFFFF_FFFC, 32'hAABB_CCDD, 0, 0);
    add(st(0, 1, 0, 0, 0, 0, 0, 0, 0),                  32'h0, 32'hAABB_CCDD, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      check_outputs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ir, tbl[i].valid, tbl[i].req, 1'b0);
    end

    // Reset during FETCH; the late ack must be ignored
    step(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
    check("midrst req", 32'(mem_req), 32'h1);
    s = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.rst_n = 1'b0;
    step(s);
    check_outputs("midrst", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);
    step(st(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    check_outputs("lateack", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);
    check("lateack state", 32'(fsm_state), 32'(ST_IDLE));

`ifdef IF_TIMEOUT_EN
    // Never acked: error after T FETCH edges, sticky until reset
    step(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < T; i++) begin
      step(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_outputs($sformatf("towait%0d", i), RESET_PC, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_outputs("timeout", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b1);
    step(st(1, 1, 3, 0, 0, 0, 32'h40, 1, 32'h1));
    check_outputs("err sticky", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b1);
    s.rst_n = 1'b0;
    step(s);
    check_outputs("err clear", RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);
    // Ack on the exact timeout edge wins
    step(st(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < T; i++) step(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(st(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678));
    check_outputs("ack at limit", RESET_PC, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized cycles against the model; scoreboard tracks fetched words
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 49) != 0);
      s.fs    = ($urandom_range(0, 3) == 0);
      s.pw    = ($urandom_range(0, 3) == 0);
      s.sel   = 2'($urandom_range(0, 3));
      s.beq   = 1'($urandom_range(0, 1));
      s.bne   = 1'($urandom_range(0, 1));
      s.zero  = 1'($urandom_range(0, 1));
      s.jr    = $urandom;
      s.ack   = ($urandom_range(0, 3) == 0);
      s.rdata = $urandom;
      step(s);
      check_outputs("rnd", m_pc, m_ir, m_valid, m_busy, m_err);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("rnd fetched word", {opcode, rs, rt, imm}, w);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
